// File: rtl/tone_envelope_gen.sv
// Square-wave tone with attack/sustain/release envelope, registered on each audio sample strobe.
// Optional mic mixing with 32-bit saturation is enabled by defining TONE_GEN_MIX_EN.
module tone_envelope_gen #(
  parameter int AMP_W    = 24,
  parameter int AMP_MAX  = 10_000_000,
  parameter int ATK_STEP = 100_000,
  parameter int REL_STEP = 50_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        note_on,
  input  logic [18:0] half_period,
  input  logic        sample_req,
  input  logic [31:0] mix_in,
  output logic [31:0] sample_out,
  output logic        active,
  output logic [1:0]  env_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ATTACK  = 2'b01,
    S_SUSTAIN = 2'b10,
    S_RELEASE = 2'b11
  } state_t;

  // One spare bit so the attack sum and release compare cannot wrap.
  localparam logic [AMP_W:0]   AMP_MAX_X = AMP_MAX[AMP_W:0];
  localparam logic [AMP_W:0]   ATK_X     = ATK_STEP[AMP_W:0];
  localparam logic [AMP_W:0]   REL_X     = REL_STEP[AMP_W:0];
  localparam logic [AMP_W-1:0] REL_N     = REL_STEP[AMP_W-1:0];

  state_t            state_q, state_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  logic [18:0]       cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [31:0]       sample_q, sample_d;

  logic [AMP_W:0]    amp_x, atk_sum;
  logic [31:0]       amp_ext, tone, out_val;

`ifdef TONE_GEN_MIX_EN
  logic [32:0]       mix_sum;
`else
  logic              mix_unused;
  assign mix_unused = ^mix_in;
`endif

  always_comb begin
    amp_x   = {1'b0, amp_q};
    atk_sum = amp_x + ATK_X;
    amp_ext = {{(32-AMP_W){1'b0}}, amp_q};
    tone    = '0;
    if (half_period != '0) begin
      tone = phase_q ? amp_ext : -amp_ext;
    end
`ifdef TONE_GEN_MIX_EN
    mix_sum = {mix_in[31], mix_in} + {tone[31], tone};
    if (mix_sum[32] != mix_sum[31]) begin
      out_val = mix_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      out_val = mix_sum[31:0];
    end
`else
    out_val = tone;
`endif
  end

  always_comb begin
    state_d  = state_q;
    amp_d    = amp_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sample_d = sample_q;

    // A shrinking half_period wraps immediately thanks to the >= compare.
    if (half_period != '0) begin
      if (cnt_q >= half_period) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 19'd1;
      end
    end

    if (sample_req) begin
      sample_d = out_val;
      unique case (state_q)
        S_IDLE: begin
          if (note_on) state_d = S_ATTACK;
        end
        S_ATTACK: begin
          if (!note_on) begin
            state_d = S_RELEASE;
          end else if (atk_sum >= AMP_MAX_X) begin
            amp_d   = AMP_MAX_X[AMP_W-1:0];
            state_d = S_SUSTAIN;
          end else begin
            amp_d = atk_sum[AMP_W-1:0];
          end
        end
        S_SUSTAIN: begin
          amp_d = AMP_MAX_X[AMP_W-1:0];
          if (!note_on) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          // Retrigger keeps the current amplitude to avoid a click.
          if (note_on) begin
            state_d = S_ATTACK;
          end else if (amp_x <= REL_X) begin
            amp_d   = '0;
            state_d = S_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            amp_d = amp_q - REL_N;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      amp_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  assign sample_out = sample_q;
  assign active     = (state_q != S_IDLE);
  assign env_state  = state_q;

endmodule

// File: tb/tb_tone_envelope_gen.sv
// Directed bench for tone_envelope_gen: envelope ramps, retrigger, tone timing, reset and mixing.
module tb_tone_envelope_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        note_on = 1'b1;
  logic        sample_req = 1'b0;
  logic [18:0] hp = 19'd100;
  logic [31:0] mix_in = '0;
  logic [31:0] sample_out;
  logic        active;
  logic [1:0]  env_state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] FULL    = 32'd10_000_000;
  localparam logic [31:0] NEGFULL = 32'hFF67_6980;

  typedef struct {
    logic        note;
    logic [1:0]  env;
    logic [31:0] mag;
  } vec_t;
  vec_t tbl[7];

  logic [31:0] s[16];

  tone_envelope_gen dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .note_on    (note_on),
    .half_period(hp),
    .sample_req (sample_req),
    .mix_in     (mix_in),
    .sample_out (sample_out),
    .active     (active),
    .env_state  (env_state)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  // Count cycles until sample_out changes; returns limit+1 on timeout.
  task automatic wait_change(input int limit, output int n);
    logic [31:0] prev;
    prev = sample_out;
    n = 0;
    while (n <= limit) begin
      step();
      n++;
      if (sample_out !== prev) return;
    end
  endtask

  task automatic wait_value(input logic [31:0] v, input int limit, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (sample_out === v) begin
        hit = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic hit;
    tbl[0] = '{1'b0, 2'b11, 32'd5_000_000};
    tbl[1] = '{1'b1, 2'b01, 32'd5_000_000};
    tbl[2] = '{1'b1, 2'b01, 32'd5_000_000};
    tbl[3] = '{1'b1, 2'b01, 32'd5_100_000};
    tbl[4] = '{1'b0, 2'b11, 32'd5_200_000};
    tbl[5] = '{1'b0, 2'b11, 32'd5_200_000};
    tbl[6] = '{1'b0, 2'b11, 32'd5_150_000};

    #5;
    check("rst_sample", sample_out, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_env", {30'd0, env_state}, 32'd0);
    step();
    step();
    rst = 1'b0;
    gap(10);
    check("idle_before_strobe", {30'd0, env_state}, 32'd0);

    // Attack: strobe 0 leaves IDLE, strobes 1..100 ramp amp to AMP_MAX.
    for (int k = 0; k <= 100; k++) begin
      strobe();
      check("atk_env", {30'd0, env_state}, (k == 100) ? 32'd2 : 32'd1);
      check("atk_mag", mag(sample_out), (k == 0) ? 32'd0 : 32'(k - 1) * 32'd100_000);
      gap(5);
    end
    strobe();
    check("sus_mag", mag(sample_out), FULL);
    check("sus_active", {31'd0, active}, 32'd1);
    gap(7);
    check("sus_hold", mag(sample_out), FULL);

    // Sustain tone with half_period 3: values are +/-FULL, inverting every 4 clocks.
    hp = 19'd3;
    sample_req = 1'b1;
    gap(6);
    for (int i = 0; i < 16; i++) begin
      s[i] = sample_out;
      step();
    end
    sample_req = 1'b0;
    for (int i = 0; i < 16; i++)
      check("sq_level", {31'd0, (s[i] === FULL) || (s[i] === NEGFULL)}, 32'd1);
    for (int i = 0; i < 12; i++)
      check("sq_period", {31'd0, s[i + 4] === -s[i]}, 32'd1);

    // Release from SUSTAIN: 200 strobes down to zero, then IDLE.
    note_on = 1'b0;
    strobe();
    check("rel_enter_env", {30'd0, env_state}, 32'd3);
    check("rel_enter_mag", mag(sample_out), FULL);
    for (int j = 1; j <= 200; j++) begin
      gap(3);
      strobe();
      check("rel_env", {30'd0, env_state}, (j == 200) ? 32'd0 : 32'd3);
      check("rel_mag", mag(sample_out), FULL - 32'(j - 1) * 32'd50_000);
    end
    gap(3);
    strobe();
    check("rel_done_sample", sample_out, 32'd0);
    check("rel_done_active", {31'd0, active}, 32'd0);

    // Attack to 5_000_000, then retrigger sequence from the table.
    note_on = 1'b1;
    strobe();
    for (int m = 1; m <= 50; m++) begin
      gap(3);
      strobe();
    end
    check("half_atk_mag", mag(sample_out), 32'd4_900_000);
    for (int r = 0; r < 7; r++) begin
      note_on = tbl[r].note;
      gap(3);
      strobe();
      check($sformatf("tbl%0d_env", r), {30'd0, env_state}, {30'd0, tbl[r].env});
      check($sformatf("tbl%0d_mag", r), mag(sample_out), tbl[r].mag);
    end

    // note_on pulse between strobes must be ignored.
    note_on = 1'b1;
    gap(2);
    note_on = 1'b0;
    gap(2);
    strobe();
    check("pulse_env", {30'd0, env_state}, 32'd3);
    check("pulse_mag", mag(sample_out), 32'd5_100_000);

    // Async reset mid-note, then re-attack from zero.
    note_on = 1'b1;
    strobe();
    gap(2);
    strobe();
    #3;
    rst = 1'b1;
    #1;
    check("arst_env", {30'd0, env_state}, 32'd0);
    check("arst_sample", sample_out, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    step();
    rst = 1'b0;
    gap(3);
    check("post_rst_env", {30'd0, env_state}, 32'd0);
    strobe();
    check("reatk_env", {30'd0, env_state}, 32'd1);
    check("reatk_mag0", mag(sample_out), 32'd0);
    gap(2);
    strobe();
    check("reatk_mag1", mag(sample_out), 32'd0);
    gap(2);
    strobe();
    check("reatk_mag2", mag(sample_out), 32'd100_000);

    n = 0;
    while (env_state != 2'b10 && n < 200) begin
      gap(2);
      strobe();
      n++;
    end
    check("reach_sustain", {30'd0, env_state}, 32'd2);

    // Muted tone gives zero sample.
    hp = 19'd0;
    gap(2);
    strobe();
    check("mute_sample", sample_out, 32'd0);

    // Shrink half_period 5000 -> 10 while cnt is 4000.
    hp = 19'd5000;
    sample_req = 1'b1;
    step();
    wait_change(12000, n);
    check("hp5000_toggle_seen", {31'd0, n <= 12000}, 32'd1);
    gap(3999);
    hp = 19'd10;
    wait_change(30, n);
    check("shrink_wrap_delay", 32'(n), 32'd2);
    wait_change(30, n);
    check("hp10_period_a", 32'(n), 32'd11);
    wait_change(30, n);
    check("hp10_period_b", 32'(n), 32'd11);

`ifdef TONE_GEN_MIX_EN
    mix_in = 32'h7FFF_FF00;
    wait_value(32'h7FFF_FFFF, 40, hit);
    check("mix_pos_sat", {31'd0, hit}, 32'd1);
    wait_value(32'h7F67_6880, 40, hit);
    check("mix_pos_nosat", {31'd0, hit}, 32'd1);
    mix_in = 32'h8000_0100;
    wait_value(32'h8000_0000, 40, hit);
    check("mix_neg_sat", {31'd0, hit}, 32'd1);
    wait_value(32'h8098_9780, 40, hit);
    check("mix_neg_nosat", {31'd0, hit}, 32'd1);
`else
    mix_in = 32'h7FFF_FF00;
    gap(2);
    for (int i = 0; i < 24; i++) begin
      step();
      check("mix_ignored", {31'd0, (sample_out === FULL) || (sample_out === NEGFULL)}, 32'd1);
    end
    wait_value(NEGFULL, 40, hit);
    check("mix_ignored_neg", {31'd0, hit}, 32'd1);
`endif
    sample_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
